// File: rtl/spi_slave_frame_if.sv
// Serial link and core-side bundle for the SPI frame responder.
// The master modport is the serial master plus AES core side.
// The slave modport is the responder block itself.
interface spi_slave_frame_if #(
  parameter int NK = 8,
  parameter int NB = 4
) ();
  localparam int MSG_W = 32 * NB;
  localparam int KEY_W = 32 * NK;

  logic             cs_enc_dec;
  logic             Mosi;
  logic             Miso;
  logic [MSG_W-1:0] msg_out;
  logic [KEY_W-1:0] key_out;
  logic             frame_valid;
  logic [MSG_W-1:0] result_in;
  logic             result_valid;
  logic             result_ready;
  logic             tx_done;

  modport master (
    output cs_enc_dec, Mosi, result_in, result_valid,
    input  Miso, msg_out, key_out, frame_valid, result_ready, tx_done
  );

  modport slave (
    input  cs_enc_dec, Mosi, result_in, result_valid,
    output Miso, msg_out, key_out, frame_valid, result_ready, tx_done
  );
endinterface

// File: rtl/spi_slave_frame.sv
// Shifts in a message+key frame on Mosi, hands it to the core, and serialises the result on Miso.
// Latency: frame_valid one cycle after the last Mosi bit; Miso MSB in the cycle after the result is accepted.
// Backpressure: result_ready is high only while waiting; cs_enc_dec high aborts any frame in progress.
module spi_slave_frame #(
  parameter int NK = 8,
  parameter int NB = 4
) (
  input  logic           in_clk,
  input  logic           rst,
  spi_slave_frame_if.slave bus
);
  localparam int MSG_W   = 32 * NB;
  localparam int KEY_W   = 32 * NK;
  localparam int FRAME_W = MSG_W + KEY_W;
  localparam logic [8:0] LAST_RX = 9'(FRAME_W - 1);
  localparam logic [8:0] LAST_TX = 9'(MSG_W - 1);

  typedef enum logic [2:0] {IDLE, RX, WAIT_RES, TX, DONE} state_t;

  state_t             state;
  logic [8:0]         cnt;
  // The final frame bit comes straight from Mosi, so only FRAME_W-1 bits are stored.
  logic [FRAME_W-2:0] rx_sh;
  // Holds the result bits not yet placed on Miso.
  logic [MSG_W-2:0]   tx_sh;
  logic [FRAME_W-1:0] rx_next;

  assign rx_next = {rx_sh, bus.Mosi};

  // Frame receive, result handoff and result transmit state machine with registered outputs.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      rx_sh            <= '0;
      tx_sh            <= '0;
      bus.msg_out      <= '0;
      bus.key_out      <= '0;
      bus.frame_valid  <= 1'b0;
      bus.result_ready <= 1'b0;
      bus.tx_done      <= 1'b0;
      bus.Miso         <= 1'b0;
    end else begin
      bus.frame_valid <= 1'b0;
      bus.tx_done     <= 1'b0;
      case (state)
        IDLE: begin
          bus.Miso <= 1'b0;
          if (!bus.cs_enc_dec) begin
            rx_sh <= {{(FRAME_W-2){1'b0}}, bus.Mosi};
            cnt   <= 9'd1;
            state <= RX;
          end
        end
        RX: begin
          if (bus.cs_enc_dec) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == LAST_RX) begin
            bus.msg_out      <= rx_next[FRAME_W-1:KEY_W];
            bus.key_out      <= rx_next[KEY_W-1:0];
            bus.frame_valid  <= 1'b1;
            bus.result_ready <= 1'b1;
            cnt              <= '0;
            state            <= WAIT_RES;
          end else begin
            rx_sh <= rx_next[FRAME_W-2:0];
            cnt   <= cnt + 9'd1;
          end
        end
        WAIT_RES: begin
          if (bus.cs_enc_dec) begin
            bus.result_ready <= 1'b0;
            state            <= IDLE;
          end else if (bus.result_valid) begin
            tx_sh            <= bus.result_in[MSG_W-2:0];
            bus.Miso         <= bus.result_in[MSG_W-1];
            bus.result_ready <= 1'b0;
            cnt              <= '0;
            state            <= TX;
          end
        end
        TX: begin
          if (bus.cs_enc_dec) begin
            bus.Miso <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end else if (cnt == LAST_TX) begin
            // Last bit has been on the line for a full cycle.
            bus.Miso    <= 1'b0;
            bus.tx_done <= 1'b1;
            cnt         <= '0;
            state       <= DONE;
          end else begin
            bus.Miso <= tx_sh[MSG_W-2];
            tx_sh    <= {tx_sh[MSG_W-3:0], 1'b0};
            cnt      <= cnt + 9'd1;
          end
        end
        DONE: begin
          bus.Miso <= 1'b0;
          if (bus.cs_enc_dec) state <= IDLE;
        end
        default: begin
          bus.Miso         <= 1'b0;
          bus.result_ready <= 1'b0;
          cnt              <= '0;
          state            <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed-plus-random bench for spi_slave_frame.
// Reference: frames are plain bit vectors; expected msg/key are slices, expected Miso bit k is result[127-k].
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_spi_slave_frame;
  localparam int MSG_W   = 128;
  localparam int KEY_W   = 256;
  localparam int FRAME_W = 384;

  logic in_clk = 1'b0;
  logic rst    = 1'b0;

  spi_slave_frame_if #(.NK(8), .NB(4)) bus ();
  spi_slave_frame #(.NK(8), .NB(4)) dut (.in_clk(in_clk), .rst(rst), .bus(bus));

  always #5 in_clk = ~in_clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [MSG_W-1:0] exp_msg;
  logic [KEY_W-1:0] exp_key;

  task automatic chk(input string tag, input logic [FRAME_W-1:0] obs, input logic [FRAME_W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [FRAME_W-1:0] rand_frame();
    logic [FRAME_W-1:0] f;
    for (int i = 0; i < FRAME_W / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  function automatic logic [MSG_W-1:0] rand_res();
    logic [MSG_W-1:0] r;
    for (int i = 0; i < MSG_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Sends the first nbits of frame f MSB first; optionally pulses result_valid mid-frame or on the last bit.
  task automatic send_frame(input logic [FRAME_W-1:0] f, input int nbits, input logic rv_last, input logic rv_mid);
    int early = 0;
    for (int i = 0; i < nbits; i++) begin
      bus.cs_enc_dec   = 1'b0;
      bus.Mosi         = f[FRAME_W-1-i];
      bus.result_valid = (rv_last && i == nbits - 1) || (rv_mid && i == nbits / 2);
      @(negedge in_clk);
      if (i != FRAME_W - 1 && bus.frame_valid) early++;
      if (bus.Miso !== 1'b0 || (i != FRAME_W - 1 && bus.result_ready !== 1'b0)) early++;
    end
    bus.result_valid = 1'b0;
    bus.Mosi = $urandom_range(0, 1);
    chk("rx_quiet_outputs", 384'(early), 384'(0));
    if (nbits == FRAME_W) begin
      exp_msg = f[FRAME_W-1 -: MSG_W];
      exp_key = f[KEY_W-1:0];
      chk("frame_valid_pulse", 384'(bus.frame_valid), 384'(1));
      chk("msg_out", 384'(bus.msg_out), 384'(exp_msg));
      chk("key_out", 384'(bus.key_out), 384'(exp_key));
      chk("wait_result_ready", 384'(bus.result_ready), 384'(1));
      @(negedge in_clk);
      chk("frame_valid_single", 384'(bus.frame_valid), 384'(0));
      chk("wait_miso_low", 384'(bus.Miso), 384'(0));
      chk("wait_ready_held", 384'(bus.result_ready), 384'(1));
    end
  endtask

  // Hands result r to the block and checks Miso bit by bit; stop_bit >= 0 ends early after that bit.
  task automatic run_result(input logic [MSG_W-1:0] r, input int stop_bit);
    int last;
    int bad_done = 0;
    last = (stop_bit >= 0) ? stop_bit : MSG_W - 1;
    bus.result_in    = r;
    bus.result_valid = 1'b1;
    @(negedge in_clk);
    bus.result_valid = 1'b0;
    bus.result_in    = rand_res();
    chk("ready_drop", 384'(bus.result_ready), 384'(0));
    chk("miso_bit0", 384'(bus.Miso), 384'(r[MSG_W-1]));
    for (int k = 1; k <= last; k++) begin
      @(negedge in_clk);
      chk("miso_bit", 384'(bus.Miso), 384'(r[MSG_W-1-k]));
      if (bus.tx_done) bad_done++;
    end
    chk("tx_done_early", 384'(bad_done), 384'(0));
    if (stop_bit < 0) begin
      @(negedge in_clk);
      chk("tx_done_pulse", 384'(bus.tx_done), 384'(1));
      chk("miso_after_tx", 384'(bus.Miso), 384'(0));
      @(negedge in_clk);
      chk("tx_done_single", 384'(bus.tx_done), 384'(0));
      chk("miso_done", 384'(bus.Miso), 384'(0));
    end
  endtask

  task automatic release_cs();
    bus.cs_enc_dec = 1'b1;
    @(negedge in_clk);
  endtask

  initial begin
    logic [FRAME_W-1:0] f;
    logic [MSG_W-1:0]   r;
    int bad;

    bus.cs_enc_dec   = 1'b1;
    bus.Mosi         = 1'b0;
    bus.result_in    = '0;
    bus.result_valid = 1'b0;
    exp_msg = '0;
    exp_key = '0;

    // Reset state
    #12;
    chk("rst_miso", 384'(bus.Miso), 384'(0));
    chk("rst_frame_valid", 384'(bus.frame_valid), 384'(0));
    chk("rst_result_ready", 384'(bus.result_ready), 384'(0));
    chk("rst_tx_done", 384'(bus.tx_done), 384'(0));
    chk("rst_msg", 384'(bus.msg_out), 384'(exp_msg));
    chk("rst_key", 384'(bus.key_out), 384'(exp_key));
    @(negedge in_clk);
    rst = 1'b1;
    @(negedge in_clk);
    @(negedge in_clk);
    chk("exit_frame_valid", 384'(bus.frame_valid), 384'(0));
    chk("exit_tx_done", 384'(bus.tx_done), 384'(0));

    // Directed frame and known result
    f = {128'h00112233445566778899aabbccddeeff,
         256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f};
    send_frame(f, FRAME_W, 1'b0, 1'b0);
    chk("directed_msg", 384'(bus.msg_out), 384'(128'h00112233445566778899aabbccddeeff));
    run_result(128'h8ea2b7ca516745bfeafc49904b496089, -1);

    // result_valid in DONE is ignored
    bus.result_in    = rand_res();
    bus.result_valid = 1'b1;
    @(negedge in_clk);
    bus.result_valid = 1'b0;
    chk("done_rv_miso", 384'(bus.Miso), 384'(0));
    chk("done_rv_ready", 384'(bus.result_ready), 384'(0));
    @(negedge in_clk);
    chk("done_rv_tx_done", 384'(bus.tx_done), 384'(0));
    chk("done_rv_miso2", 384'(bus.Miso), 384'(0));
    release_cs();

    // Abort after 200 bits with a stray result_valid mid-frame
    send_frame(rand_frame(), 200, 1'b0, 1'b1);
    release_cs();
    chk("abort_frame_valid", 384'(bus.frame_valid), 384'(0));
    chk("abort_ready", 384'(bus.result_ready), 384'(0));
    chk("abort_msg_kept", 384'(bus.msg_out), 384'(exp_msg));
    chk("abort_key_kept", 384'(bus.key_out), 384'(exp_key));

    // Full random frame with result_valid on the completing edge (ignored)
    send_frame(rand_frame(), FRAME_W, 1'b1, 1'b0);
    run_result(rand_res(), -1);
    release_cs();

    // Asynchronous reset during TX bit 60
    send_frame(rand_frame(), FRAME_W, 1'b0, 1'b0);
    run_result(rand_res(), 60);
    #2;
    rst = 1'b0;
    #1;
    exp_msg = '0;
    exp_key = '0;
    chk("arst_miso", 384'(bus.Miso), 384'(0));
    chk("arst_ready", 384'(bus.result_ready), 384'(0));
    chk("arst_frame_valid", 384'(bus.frame_valid), 384'(0));
    chk("arst_tx_done", 384'(bus.tx_done), 384'(0));
    chk("arst_msg", 384'(bus.msg_out), 384'(exp_msg));
    chk("arst_key", 384'(bus.key_out), 384'(exp_key));
    bus.cs_enc_dec = 1'b1;
    @(negedge in_clk);
    rst = 1'b1;
    @(negedge in_clk);
    send_frame(rand_frame(), FRAME_W, 1'b0, 1'b0);
    run_result(rand_res(), -1);
    release_cs();

    // Long wait for a result, then abort with chip select
    send_frame(rand_frame(), FRAME_W, 1'b0, 1'b0);
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge in_clk);
      if (bus.result_ready !== 1'b1 || bus.Miso !== 1'b0) bad++;
    end
    chk("long_wait", 384'(bad), 384'(0));
    release_cs();
    chk("wait_abort_ready", 384'(bus.result_ready), 384'(0));
    r = rand_res();
    bus.result_in    = r;
    bus.result_valid = 1'b1;
    @(negedge in_clk);
    bus.result_valid = 1'b0;
    chk("idle_rv_miso", 384'(bus.Miso), 384'(0));
    chk("idle_rv_ready", 384'(bus.result_ready), 384'(0));
    chk("idle_msg_kept", 384'(bus.msg_out), 384'(exp_msg));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_frame.md
Name: spi_slave_frame

Overview:
- Serial-side responder for the encryption/decryption link, sitting between the serial master and the AES core.
- Shifts in one message+key frame on Mosi while chip select is low, then presents the frame to the core in parallel.
- Waits for the core result, then shifts that result back to the master on Miso, MSB first.

Parameters:
- NK, 8, key length in 32-bit words; KEY_W = 32*NK (256).
- NB, 4, block length in 32-bit words; MSG_W = 32*NB (128).

Ports:
- in_clk  input  1  single clock; all sampling and driving on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cs_enc_dec  input  1  chip select from master; active low; frame lasts while low.
- Mosi  input  1  serial data from master; message first, then key; MSB first.
- Miso  output  1  serial result to master; MSB first.
- msg_out  output  MSG_W  captured message.
- key_out  output  KEY_W  captured key.
- frame_valid  output  1  one-cycle pulse when msg_out/key_out are complete.
- result_in  input  MSG_W  core result.
- result_valid  input  1  core result strobe.
- result_ready  output  1  high while the block accepts a result.
- tx_done  output  1  one-cycle pulse after the last Miso bit.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE;
  - msg_out, key_out and the shift registers to 0;
  - frame_valid, result_ready, tx_done and Miso to 0;
  - bit counter to 0.
- Reset mid-frame discards all partial data. No pulse is generated on reset exit.
- Bit counter is 9 bits wide and counts 0 to MSG_W+KEY_W-1 (383). It is reused for TX, counting 0 to MSG_W-1.

State machine:
- IDLE:
  - On a clock edge with cs_enc_dec=0, sample Mosi as bit 0 (message MSB), set counter=1, go to RX.
- RX:
  - Each edge with cs_enc_dec=0: shift Mosi into a (MSG_W+KEY_W)-bit register, LSB-in, and increment the counter.
  - On the edge sampling bit 383, load msg_out = upper MSG_W bits and key_out = lower KEY_W bits.
  - On that same edge, pulse frame_valid for exactly one cycle (the cycle after that edge) and go to WAIT_RES.
- WAIT_RES:
  - result_ready=1.
  - On an edge with result_valid=1: capture result_in into the TX shift register, drop result_ready, set counter=0, drive Miso=result_in[MSG_W-1], go to TX.
  - The result is accepted on the same edge it is seen, so result_valid only needs to be high for one cycle.
- TX:
  - Each edge shifts the next bit onto Miso. Bit k is on Miso during the cycle following edge k.
  - After bit MSG_W-1 has been driven for one cycle: drive Miso=0, pulse tx_done for one cycle, go to DONE.
- DONE:
  - Miso=0; wait for cs_enc_dec=1, then go to IDLE.

Boundary conditions:
- cs_enc_dec=1 in RX, WAIT_RES or TX aborts to IDLE on that edge:
  - no frame_valid and no tx_done pulse;
  - result_ready=0 and Miso=0;
  - msg_out and key_out keep their previous values.
- result_valid outside WAIT_RES is ignored.
- result_valid on the same edge that RX completes is ignored; WAIT_RES is entered first.
- Mosi is not sampled outside IDLE and RX.
- A new frame needs cs_enc_dec to go high for at least one edge after DONE.
- Back-to-back frames with cs held low are not supported.
- msg_out and key_out change only on a successful frame completion.

Test Plan:
- Send plaintext 00112233445566778899aabbccddeeff, then key 000102...1f, 384 bits MSB first -> frame_valid pulses exactly once, 384 edges after the first sample, with msg_out and key_out equal to the sent values.
- After the previous case, assert result_valid for one cycle with result_in = 8ea2b7ca516745bfeafc49904b496089 -> result_ready drops, Miso serialises 8ea2...6089 MSB first over 128 cycles, tx_done pulses once, then Miso=0.
- Raise cs_enc_dec after 200 bits -> state IDLE, no frame_valid, msg_out/key_out unchanged; a following full frame is captured correctly.
- Pulse result_valid during RX and again in DONE -> ignored; Miso stays 0 and no extra tx_done pulse.
- Assert rst=0 asynchronously mid-TX (bit 60) -> all outputs 0 immediately without a clock edge; after release, a full frame and result round-trip succeeds.
- Hold result_valid low for 1000 cycles in WAIT_RES -> result_ready stays 1, Miso stays 0; raising cs_enc_dec returns the block to IDLE.
